// File: rtl/muldiv_ctrl_pkg.sv
// ============================================================================
// Module   : muldiv_ctrl_pkg
// Brief    : Shared types for the MIPS multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package muldiv_ctrl_pkg;

    typedef logic        i1;
    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DIV_FIX = 2'd3
    } muldiv_state_t;

    // Magnitude of a two's-complement value; passes the raw value when unsigned.
    function automatic i32 abs32(input i32 v, input i1 is_signed);
        return (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_core.sv
// ============================================================================
// Module   : div_core
// Brief    : 32-step restoring divider iterator on unsigned magnitudes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_core
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    i32          rem_q;
    i32          quo_q;
    i32          dvsr_q;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // Shift rem:quo left by one, then trial-subtract the divisor from the top half.
    assign w_rem_sh = {rem_q, quo_q[31]};
    assign w_diff   = w_rem_sh - {1'b0, dvsr_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else if (load) begin
            rem_q  <= '0;
            quo_q  <= dividend;
            dvsr_q <= divisor;
        end else if (step) begin
            if (!w_diff[32]) begin
                rem_q <= w_diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= w_rem_sh[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// Module   : muldiv_ctrl
// Brief    : Sequences MULT/MULTU/DIV/DIVU and MTHI/MTLO onto the hi/lo pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        mt_hi,
    input  logic        mt_lo,
    input  logic [31:0] mt_data,
    output logic        busy,
    output logic        done,
    output logic        mt_ready,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

    muldiv_state_t state_q;
    logic [4:0]    cnt_q;
    i64            prod_q;
    i32            a_q;
    logic          quo_neg_q;
    logic          rem_neg_q;
    logic          dbz_q;

    muldiv_op_t    w_op;
    logic          w_idle;
    logic          w_launch;
    logic          w_is_div;
    logic          w_signed;
    i64            w_ext_a;
    i64            w_ext_b;
    i64            w_prod;
    i32            w_abs_a;
    i32            w_abs_b;
    i32            w_quo;
    i32            w_rem;
    i32            w_div_lo;
    i32            w_div_hi;
    logic          w_res_done;

    assign w_op     = muldiv_op_t'(op);
    assign w_idle   = (state_q == ST_IDLE);
    assign w_launch = w_idle && start && !flush;
    assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
    assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);

    // Sign/zero-extend to 64 bits; the low 64 bits of the product are then exact.
    assign w_ext_a  = {{32{w_signed & a[31]}}, a};
    assign w_ext_b  = {{32{w_signed & b[31]}}, b};
    assign w_prod   = w_ext_a * w_ext_b;

    assign w_abs_a  = abs32(a, w_signed);
    assign w_abs_b  = abs32(b, w_signed);

    div_core u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .load     (w_launch && w_is_div),
        .step     ((state_q == ST_DIV_RUN) && !flush),
        .dividend (w_abs_a),
        .divisor  (w_abs_b),
        .quo      (w_quo),
        .rem      (w_rem)
    );

    assign w_div_lo = dbz_q ? 32'hFFFF_FFFF : (quo_neg_q ? -w_quo : w_quo);
    assign w_div_hi = dbz_q ? a_q           : (rem_neg_q ? -w_rem : w_rem);

    assign w_res_done = !flush &&
                        (((state_q == ST_MUL_RUN) && (cnt_q == 5'd0)) ||
                         (state_q == ST_DIV_FIX));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            a_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if (flush) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_launch) begin
                        a_q <= a;
                        if (w_is_div) begin
                            cnt_q     <= 5'd31;
                            quo_neg_q <= (w_op == MD_DIV) && (a[31] ^ b[31]);
                            rem_neg_q <= (w_op == MD_DIV) && a[31];
                            dbz_q     <= (b == 32'd0);
                            state_q   <= ST_DIV_RUN;
                        end else begin
                            prod_q  <= w_prod;
                            cnt_q   <= 5'(MUL_LAT - 1);
                            state_q <= ST_MUL_RUN;
                        end
                    end
                end
                ST_MUL_RUN: begin
                    if (cnt_q == 5'd0) state_q <= ST_IDLE;
                    else               cnt_q   <= cnt_q - 5'd1;
                end
                ST_DIV_RUN: begin
                    if (cnt_q == 5'd0) state_q <= ST_DIV_FIX;
                    else               cnt_q   <= cnt_q - 5'd1;
                end
                ST_DIV_FIX: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // A completing result owns hi/lo; MT requests only reach hilo while idle.
    always_comb begin
        busy     = !w_idle;
        done     = w_res_done;
        mt_ready = w_idle;
        hi_write = 1'b0;
        lo_write = 1'b0;
        hi_data  = '0;
        lo_data  = '0;
        if (w_res_done) begin
            hi_write = 1'b1;
            lo_write = 1'b1;
            if (state_q == ST_MUL_RUN) begin
                hi_data = prod_q[63:32];
                lo_data = prod_q[31:0];
            end else begin
                hi_data = w_div_hi;
                lo_data = w_div_lo;
            end
        end else if (w_idle && resetn) begin
            hi_write = mt_hi;
            lo_write = mt_lo;
            hi_data  = mt_hi ? mt_data : 32'd0;
            lo_data  = mt_lo ? mt_data : 32'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ============================================================================
// Module   : tb_muldiv_ctrl
// Brief    : Directed scoreboard bench for muldiv_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic [31:0] mt_data = '0;
    logic        busy, done, mt_ready, hi_write, lo_write;
    logic [31:0] hi_data, lo_data;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .mt_hi    (mt_hi),
        .mt_lo    (mt_lo),
        .mt_data  (mt_data),
        .busy     (busy),
        .done     (done),
        .mt_ready (mt_ready),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .hi_data  (hi_data),
        .lo_data  (lo_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic launch_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        sb.push_back('{hi: ehi, lo: elo, cyc: cyc + lat});
        launch(o, x, y);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        tick();
        chk("idle_after_drain", {63'd0, busy}, 64'd0);
    endtask

    // Every result write is matched against the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res_hi", 64'(hi_data), 64'(e.hi));
                chk("res_lo", 64'(lo_data), 64'(e.lo));
                chk("res_strobes", {62'd0, hi_write, lo_write}, 64'd3);
                chk("res_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_mt_ready", {63'd0, mt_ready}, 64'd1);
        chk("rst_strobes", {62'd0, hi_write, lo_write}, 64'd0);
        chk("rst_data", {hi_data, lo_data}, 64'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        // Multiplies
        launch_exp(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT);
        chk("mul_busy", {63'd0, busy}, 64'd1);
        chk("mul_mt_ready", {63'd0, mt_ready}, 64'd0);
        drain();
        launch_exp(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT);
        drain();

        // Divide busy length and signed fix-up
        launch_exp(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("div_busy_cycles", 64'(n), 64'd33);
        drain();
        launch_exp(MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        drain();
        launch_exp(MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 33);
        drain();
        launch_exp(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 33);
        drain();

        // Divide corner cases
        launch_exp(MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
        drain();
        launch_exp(MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 33);
        drain();
        launch_exp(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        drain();

        // Flush on the 10th DIV_RUN cycle, then a MULT straight after
        launch(MD_DIV, 32'd1000, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        #1;
        chk("flush_done", {63'd0, done}, 64'd0);
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        launch_exp(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, LAT);
        drain();
        repeat (40) tick();

        // start together with flush in IDLE is dropped
        op = MD_MULT; a = 32'd2; b = 32'd3; flush = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (LAT + 2) tick();

        // MTHI held across a divide; start while busy is ignored
        launch_exp(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        launch(MD_MULT, 32'd9, 32'd9);
        mt_hi = 1'b1; mt_data = 32'h0000_1234;
        bad = 0; n = 0;
        while (busy && n < 100) begin
            if (mt_ready) bad++;
            n++;
            tick();
        end
        chk("mt_ready_while_busy", 64'(bad), 64'd0);
        chk("mt_ready_idle", {63'd0, mt_ready}, 64'd1);
        chk("mthi_strobes", {62'd0, hi_write, lo_write}, 64'd2);
        chk("mthi_data", {hi_data, lo_data}, {32'h0000_1234, 32'd0});
        tick();
        mt_hi = 1'b0;
        chk("sb_after_mt", 64'(sb.size()), 64'd0);

        // MTHI and MTLO together
        mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'hCAFE_F00D;
        #1;
        chk("mt_both_strobes", {62'd0, hi_write, lo_write}, 64'd3);
        chk("mt_both_data", {hi_data, lo_data}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        tick();
        mt_hi = 1'b0; mt_lo = 1'b0;

        // MTLO in the same cycle as a launch
        mt_lo = 1'b1; mt_data = 32'h5555_AAAA;
        op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1;
        sb.push_back('{hi: 32'd0, lo: 32'd15, cyc: cyc + LAT});
        #1;
        chk("mt_launch_strobes", {62'd0, hi_write, lo_write}, 64'd1);
        chk("mt_launch_data", {hi_data, lo_data}, {32'd0, 32'h5555_AAAA});
        tick();
        start = 1'b0; mt_lo = 1'b0;
        drain();

        // Async reset mid-divide
        launch(MD_DIV, 32'd50, 32'd5);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_strobes", {62'd0, hi_write, lo_write}, 64'd0);
        chk("arst_data", {hi_data, lo_data}, 64'd0);
        tick(); tick();
        resetn = 1'b1;
        repeat (40) tick();
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
